board_ctrl: RTL and testbench
=============================

BOARD_CTRL -- requirements
Module: board_ctrl

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- DATA_W, 32, width of the monitored CPU value (legal range 25..48).
- DIV_W, 25, divider counter width.
- NUM_KEYS, 2, number of push buttons (minimum 2).
- DB_CYCLES, 50000, debounce stability window in clk cycles.
REQ-002 Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, board clock.
- rst, in, 1, asynchronous active-low reset.
- key_n, in, NUM_KEYS, raw buttons; 0 = pressed.
- mode, in, 2, 00 full-speed, 01 divided, 10 single-step, 11 halt.
- div_sel, in, $clog2(DIV_W), divide exponent.
- data_in, in, DATA_W, CPU result value (a0).
- cpu_en, out, 1, CPU clock-enable pulse.
- key_level, out, NUM_KEYS, debounced pressed level.
- key_press, out, NUM_KEYS, one-cycle pulse per debounced press.
- disp_data, out, 24, six-nibble value for the hex display.
- disp_page, out, 1, 0 = low page, 1 = high page.
- step_count, out, 16, count of cpu_en pulses.

Function
REQ-004 Each key_n bit SHALL pass through a 2-flop synchroniser before any other use.
REQ-005 Debounce SHALL work per key as follows.
- A per-key counter increments while the synchronised pressed value differs from key_level.
- The counter clears whenever the two agree.
- key_level toggles in the cycle the counter reaches DB_CYCLES-1; the counter then clears.
REQ-006 key_press[i] SHALL be high for exactly one cycle, the cycle in which key_level[i] rises 0->1; release SHALL produce no pulse.
REQ-007 In mode 00, cpu_en SHALL be 1 every cycle.
REQ-008 In mode 01, a tick counter SHALL count 0..2^div_sel-1 and wrap.
- cpu_en = 1 in the wrap cycle only.
- div_sel=0 gives cpu_en every cycle.
- div_sel values >= DIV_W SHALL behave as DIV_W-1.
REQ-009 In mode 10, cpu_en SHALL pulse for exactly one cycle, the cycle after key_press[0].
- Presses of key 0 in any other mode SHALL be ignored and not queued.
REQ-010 In mode 11, cpu_en SHALL be 0.
REQ-011 Any change of mode or div_sel SHALL clear the tick counter.
- No cpu_en pulse is issued in the change cycle, even if the counter was at terminal count.
REQ-012 A pending single-step pulse SHALL be discarded if mode leaves 10 in the same cycle.
REQ-013 step_count SHALL increment by 1 in each cycle where cpu_en=1 and wrap 16'hFFFF->0.
REQ-014 A snapshot register SHALL capture data_in in the cycle after each cpu_en=1 cycle and otherwise hold.
REQ-015 disp_page SHALL toggle on each key_press[NUM_KEYS-1] pulse.
REQ-016 disp_data SHALL be combinational from the snapshot register and disp_page.
- disp_page=0: snapshot[23:0].
- disp_page=1: snapshot[DATA_W-1:24], zero-extended to 24 bits.
REQ-017 Simultaneous key presses SHALL each be honoured in the same cycle.
- Page toggle and step pulse are independent.

Reset
REQ-018 While rst=0, regardless of clk, the following SHALL hold.
- Synchroniser flops = 1 (released).
- key_level, key_press, cpu_en, disp_page = 0.
- step_count = 0.
- Snapshot, tick counter and debounce counters = 0.
REQ-019 After rst rises, the first cpu_en SHALL occur no earlier than the first rising clk edge after release.
REQ-020 Reset asserted mid-debounce or mid-divide SHALL discard all partial counts.

Verification (DB_CYCLES=4, DIV_W=8, DATA_W=32)
REQ-021 Bounce rejection: key_n[0] low 3 cycles, high 1 cycle, low 10 cycles -> exactly one key_press[0] pulse, 2+4 cycles after the final fall; key_level[0]=1 thereafter.
REQ-022 Divided mode: mode=01, div_sel=3 for 40 cycles -> cpu_en pulses every 8th cycle (5 pulses); step_count=5.
REQ-023 Single step: mode=10, data_in=32'hDEADBEEF, one clean press of key 0 -> one cpu_en pulse.
- step_count 0->1.
- disp_data=24'hADBEEF.
- After a key 1 press, disp_data=24'h0000DE.
REQ-024 Mode change at terminal count: mode=01, div_sel=2, switch mode to 11 on the terminal cycle -> no cpu_en pulse in that cycle or after.
REQ-025 Wrap and reset: preload step_count to 16'hFFFF via mode 00, then 1 more cycle -> step_count=0; assert rst mid-count -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/board_ctrl.sv
// board_ctrl: push-button synchronise/debounce, CPU clock-enable generation
// (run / divide / single-step / halt) and a paged hex-display snapshot of the CPU result.
module board_ctrl #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned DIV_W     = 25,
  parameter int unsigned NUM_KEYS  = 2,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_KEYS-1:0]      key_n,
  input  logic [1:0]               mode,
  input  logic [$clog2(DIV_W)-1:0] div_sel,
  input  logic [DATA_W-1:0]        data_in,
  output logic                     cpu_en,
  output logic [NUM_KEYS-1:0]      key_level,
  output logic [NUM_KEYS-1:0]      key_press,
  output logic [23:0]              disp_data,
  output logic                     disp_page,
  output logic [15:0]              step_count
);

  localparam int unsigned SEL_W = $clog2(DIV_W);
  localparam int unsigned DB_W  = $clog2(DB_CYCLES + 1);

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_DIV  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_HALT = 2'b11;

  logic [NUM_KEYS-1:0]           sync1;
  logic [NUM_KEYS-1:0]           sync2;
  logic [NUM_KEYS-1:0]           pressed;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt;
  logic [NUM_KEYS-1:0][DB_W-1:0] db_cnt_nx;
  logic [NUM_KEYS-1:0]           level_nx;
  logic [NUM_KEYS-1:0]           press_nx;

  logic [1:0]        mode_q;
  logic [SEL_W-1:0]  div_q;
  logic [SEL_W-1:0]  sel_eff;
  logic [DIV_W-1:0]  tick;
  logic [DIV_W-1:0]  tick_nx;
  logic [DIV_W-1:0]  tick_max;
  logic              changed;
  logic              en_nx;
  logic [DATA_W-1:0] snap;

  assign pressed = ~sync2;

  // Per-key debounce: level flips once the raw value has disagreed for DB_CYCLES cycles
  always_comb begin
    db_cnt_nx = '0;
    level_nx  = key_level;
    press_nx  = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (pressed[i] != key_level[i]) begin
        if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          level_nx[i] = pressed[i];
          press_nx[i] = pressed[i];
        end else begin
          db_cnt_nx[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Out-of-range divide exponents saturate at the largest legal one
  assign sel_eff  = (div_sel >= SEL_W'(DIV_W - 1)) ? SEL_W'(DIV_W - 1) : div_sel;
  assign tick_max = (DIV_W'(1) << sel_eff) - DIV_W'(1);
  assign changed  = (mode != mode_q) || (div_sel != div_q);

  always_comb begin
    en_nx   = 1'b0;
    tick_nx = '0;
    case (mode)
      MODE_RUN:  en_nx = 1'b1;
      MODE_DIV: begin
        // A mode/divider change restarts the period and swallows any due pulse
        if (!changed) begin
          if (tick == tick_max) en_nx = 1'b1;
          else                  tick_nx = tick + 1'b1;
        end
      end
      MODE_STEP: en_nx = key_press[0];
      MODE_HALT: en_nx = 1'b0;
      default:   en_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1      <= '1;
      sync2      <= '1;
      db_cnt     <= '0;
      key_level  <= '0;
      key_press  <= '0;
      mode_q     <= '0;
      div_q      <= '0;
      tick       <= '0;
      cpu_en     <= 1'b0;
      step_count <= '0;
      snap       <= '0;
      disp_page  <= 1'b0;
    end else begin
      sync1     <= key_n;
      sync2     <= sync1;
      db_cnt    <= db_cnt_nx;
      key_level <= level_nx;
      key_press <= press_nx;
      mode_q    <= mode;
      div_q     <= div_sel;
      tick      <= tick_nx;
      cpu_en    <= en_nx;
      if (cpu_en) begin
        step_count <= step_count + 16'd1;
        snap       <= data_in;
      end
      disp_page <= disp_page ^ key_press[NUM_KEYS-1];
    end
  end

  assign disp_data = disp_page ? 24'(snap >> 24) : snap[23:0];

endmodule

// File: tb/tb_board_ctrl.sv
// Testbench for board_ctrl: a table of directed vectors plus hand-written
// sequences for bounce, divided mode, terminal-count mode change and wrap/reset.
module tb_board_ctrl;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned DIV_W     = 8;
  localparam int unsigned NUM_KEYS  = 2;
  localparam int unsigned DB_CYCLES = 4;
  localparam int          NV        = 18;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        key_n;
  logic [1:0]        mode;
  logic [2:0]        div_sel;
  logic [DATA_W-1:0] data_in;
  logic              cpu_en;
  logic [1:0]        key_level;
  logic [1:0]        key_press;
  logic [23:0]       disp_data;
  logic              disp_page;
  logic [15:0]       step_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  typedef struct {
    logic [1:0]  key_n;
    logic [1:0]  mode;
    logic [2:0]  div_sel;
    logic [31:0] data_in;
    int          cyc;
    logic        cpu_en;
    logic [1:0]  level;
    logic [1:0]  press;
    logic        page;
    logic [15:0] steps;
    logic [23:0] disp;
  } vec_t;

  vec_t tbl [NV];

  board_ctrl #(
    .DATA_W   (DATA_W),
    .DIV_W    (DIV_W),
    .NUM_KEYS (NUM_KEYS),
    .DB_CYCLES(DB_CYCLES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_n     (key_n),
    .mode      (mode),
    .div_sel   (div_sel),
    .data_in   (data_in),
    .cpu_en    (cpu_en),
    .key_level (key_level),
    .key_press (key_press),
    .disp_data (disp_data),
    .disp_page (disp_page),
    .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic [1:0] m, input logic [2:0] d);
    rst     = 1'b0;
    key_n   = 2'b11;
    mode    = m;
    div_sel = d;
    step(3);
    check("rst_cpu_en", cpu_en, 0);
    check("rst_level", key_level, 0);
    check("rst_press", key_press, 0);
    check("rst_page", disp_page, 0);
    check("rst_steps", step_count, 0);
    check("rst_disp", disp_data, 0);
    rst = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    int pos;
    int last;
    bit found;

    tbl[0]  = '{2'b11, 2'b11, 3'd0, 32'hDEADBEEF, 3, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, 24'h000000};
    tbl[1]  = '{2'b10, 2'b10, 3'd0, 32'hDEADBEEF, 5, 1'b0, 2'b00, 2'b00, 1'b0, 16'd0, 24'h000000};
    tbl[2]  = '{2'b10, 2'b10, 3'd0, 32'hDEADBEEF, 1, 1'b0, 2'b01, 2'b01, 1'b0, 16'd0, 24'h000000};
    tbl[3]  = '{2'b10, 2'b10, 3'd0, 32'hDEADBEEF, 1, 1'b1, 2'b01, 2'b00, 1'b0, 16'd0, 24'h000000};
    tbl[4]  = '{2'b10, 2'b10, 3'd0, 32'hDEADBEEF, 1, 1'b0, 2'b01, 2'b00, 1'b0, 16'd1, 24'hADBEEF};
    tbl[5]  = '{2'b11, 2'b10, 3'd0, 32'hDEADBEEF, 6, 1'b0, 2'b00, 2'b00, 1'b0, 16'd1, 24'hADBEEF};
    tbl[6]  = '{2'b01, 2'b10, 3'd0, 32'hDEADBEEF, 6, 1'b0, 2'b10, 2'b10, 1'b0, 16'd1, 24'hADBEEF};
    tbl[7]  = '{2'b01, 2'b10, 3'd0, 32'hDEADBEEF, 1, 1'b0, 2'b10, 2'b00, 1'b1, 16'd1, 24'h0000DE};
    tbl[8]  = '{2'b11, 2'b00, 3'd0, 32'h12345678, 1, 1'b1, 2'b10, 2'b00, 1'b1, 16'd1, 24'h0000DE};
    tbl[9]  = '{2'b11, 2'b00, 3'd0, 32'h12345678, 1, 1'b1, 2'b10, 2'b00, 1'b1, 16'd2, 24'h000012};
    tbl[10] = '{2'b11, 2'b11, 3'd0, 32'h12345678, 1, 1'b0, 2'b10, 2'b00, 1'b1, 16'd3, 24'h000012};
    tbl[11] = '{2'b11, 2'b11, 3'd0, 32'h12345678, 4, 1'b0, 2'b00, 2'b00, 1'b1, 16'd3, 24'h000012};
    tbl[12] = '{2'b10, 2'b11, 3'd0, 32'h12345678, 8, 1'b0, 2'b01, 2'b00, 1'b1, 16'd3, 24'h000012};
    tbl[13] = '{2'b10, 2'b10, 3'd0, 32'h12345678, 3, 1'b0, 2'b01, 2'b00, 1'b1, 16'd3, 24'h000012};
    tbl[14] = '{2'b11, 2'b10, 3'd0, 32'h12345678, 6, 1'b0, 2'b00, 2'b00, 1'b1, 16'd3, 24'h000012};
    tbl[15] = '{2'b00, 2'b10, 3'd0, 32'hCAFEF00D, 6, 1'b0, 2'b11, 2'b11, 1'b1, 16'd3, 24'h000012};
    tbl[16] = '{2'b00, 2'b10, 3'd0, 32'hCAFEF00D, 1, 1'b1, 2'b11, 2'b00, 1'b0, 16'd3, 24'h345678};
    tbl[17] = '{2'b00, 2'b10, 3'd0, 32'hCAFEF00D, 1, 1'b0, 2'b11, 2'b00, 1'b0, 16'd4, 24'hFEF00D};

    data_in = 32'hDEADBEEF;
    do_reset(2'b11, 3'd0);

    for (int i = 0; i < NV; i++) begin
      key_n   = tbl[i].key_n;
      mode    = tbl[i].mode;
      div_sel = tbl[i].div_sel;
      data_in = tbl[i].data_in;
      step(tbl[i].cyc);
      check($sformatf("v%0d_cpu_en", i), cpu_en, tbl[i].cpu_en);
      check($sformatf("v%0d_level", i), key_level, tbl[i].level);
      check($sformatf("v%0d_press", i), key_press, tbl[i].press);
      check($sformatf("v%0d_page", i), disp_page, tbl[i].page);
      check($sformatf("v%0d_steps", i), step_count, tbl[i].steps);
      check($sformatf("v%0d_disp", i), disp_data, tbl[i].disp);
    end

    // Bounce: low 3, high 1, low 10 -> single press 6 cycles after the last fall
    do_reset(2'b11, 3'd0);
    pulses = 0;
    pos    = -1;
    key_n  = 2'b10;
    for (int c = 0; c < 3; c++) begin
      step(1);
      if (key_press[0]) pulses++;
    end
    key_n = 2'b11;
    step(1);
    if (key_press[0]) pulses++;
    key_n = 2'b10;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (key_press[0]) begin
        pulses++;
        pos = c;
      end
    end
    check("bounce_pulses", pulses, 1);
    check("bounce_delay", pos, 6);
    check("bounce_level", key_level[0], 1);

    // Reset mid-debounce discards partial progress
    key_n = 2'b11;
    step(8);
    check("release_level", key_level, 0);
    key_n = 2'b10;
    step(4);
    rst = 1'b0;
    step(1);
    check("middb_rst_level", key_level, 0);
    rst = 1'b1;
    step(5);
    check("middb_level_early", key_level[0], 0);
    step(1);
    check("middb_level", key_level[0], 1);
    check("middb_press", key_press[0], 1);

    // Divided mode, div_sel=3
    do_reset(2'b01, 3'd3);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (cpu_en) found = 1'b1;
    end
    check("div_first_pulse", found, 1);
    pulses = 0;
    last   = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) step(1);
      if (cpu_en) begin
        if (k > 0) check("div_gap", k - last, 8);
        last = k;
        pulses++;
      end
    end
    check("div_pulses", pulses, 5);
    check("div_steps", step_count, 5);

    // div_sel change on a terminal cycle: no pulse, then div_sel=0 runs every cycle
    div_sel = 3'd0;
    step(1);
    check("divchg_suppress", cpu_en, 0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      check("div0_every", cpu_en, 1);
    end

    // Mode change to halt on the terminal cycle of div_sel=2
    div_sel = 3'd2;
    found   = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step(1);
      if (cpu_en) found = 1'b1;
    end
    check("div2_pulse", found, 1);
    step(3);
    check("term_cycle_en", cpu_en, 0);
    mode   = 2'b11;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (cpu_en) pulses++;
    end
    check("term_halt_pulses", pulses, 0);

    // Wrap of step_count in run mode, then asynchronous reset
    data_in = 32'h5A00ABCD;
    do_reset(2'b00, 3'd0);
    #1;
    check("release_no_en", cpu_en, 0);
    key_n = 2'b01;
    step(1);
    check("run_en", cpu_en, 1);
    found = 1'b0;
    for (int k = 0; k < 70000 && !found; k++) begin
      if (step_count == 16'hFFFF) found = 1'b1;
      else step(1);
    end
    check("wrap_reached", found, 1);
    check("wrap_ffff", step_count, 16'hFFFF);
    check("wrap_page", disp_page, 1);
    check("wrap_level", key_level, 2'b10);
    check("wrap_disp", disp_data, 24'h00005A);
    step(1);
    check("wrap_zero", step_count, 0);
    step(2);
    check("wrap_two", step_count, 2);
    #2;
    rst = 1'b0;
    #1;
    check("async_cpu_en", cpu_en, 0);
    check("async_steps", step_count, 0);
    check("async_level", key_level, 0);
    check("async_press", key_press, 0);
    check("async_page", disp_page, 0);
    check("async_disp", disp_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
